// File: rtl/hazard_pattern_gen.sv
// N-wide hazard LED bar with four prescaler-paced patterns (calm, wind right, wind left, bounce).
// Bounce is only built when HAZARD_BOUNCE_EN is defined; otherwise mode 11 behaves as calm.
//
// state    | meaning
// M_CALM   | OUTSIDE <-> CENTER alternation
// M_WIND_R | single LED rotating toward bit 0
// M_WIND_L | single LED rotating toward bit N_LEDS-1
// M_BOUNCE | single LED ping-ponging between the ends
module hazard_pattern_gen #(
  parameter int N_LEDS   = 10,
  parameter int TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] leds,
  output logic              step
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [N_LEDS-1:0] OUTSIDE = {1'b1, {(N_LEDS-2){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] MSB_LIT = {1'b1, {(N_LEDS-1){1'b0}}};
  localparam logic [N_LEDS-1:0] LSB_LIT = N_LEDS'(1);

  function automatic logic [N_LEDS-1:0] center_pat();
    logic [N_LEDS-1:0] p;
    p = '0;
    if (N_LEDS % 2 == 0) begin
      p[N_LEDS/2]   = 1'b1;
      p[N_LEDS/2-1] = 1'b1;
    end else begin
      p[(N_LEDS-1)/2] = 1'b1;
    end
    return p;
  endfunction

  localparam logic [N_LEDS-1:0] CENTER = center_pat();

  typedef enum logic [1:0] {
    M_CALM   = 2'b00,
    M_WIND_R = 2'b01,
    M_WIND_L = 2'b10,
    M_BOUNCE = 2'b11
  } mode_t;

  mode_t             applied;
  mode_t             req;
  logic [CW-1:0]     count;
  logic              tick;
  logic [N_LEDS-1:0] next_leds;

`ifdef HAZARD_BOUNCE_EN
  logic dir_left;
  logic next_dir_left;
`endif

  assign tick = enable && (count == CNT_LAST);

  always_comb begin
`ifdef HAZARD_BOUNCE_EN
    req = mode_t'(mode);
`else
    // Without bounce hardware, 11 aliases calm so 00<->11 is not a mode change.
    req = (mode == 2'b11) ? M_CALM : mode_t'(mode);
`endif
  end

  always_comb begin
    next_leds = leds;
`ifdef HAZARD_BOUNCE_EN
    next_dir_left = dir_left;
`endif
    if (req != applied) begin
      case (req)
        M_CALM:   next_leds = OUTSIDE;
        M_WIND_R: next_leds = MSB_LIT;
        M_WIND_L: next_leds = LSB_LIT;
        default: begin
          next_leds = MSB_LIT;
`ifdef HAZARD_BOUNCE_EN
          next_dir_left = 1'b0;
`endif
        end
      endcase
    end else begin
      case (applied)
        M_CALM:   next_leds = (leds == OUTSIDE) ? CENTER : OUTSIDE;
        M_WIND_R: next_leds = {leds[0], leds[N_LEDS-1:1]};
        M_WIND_L: next_leds = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
        default: begin
`ifdef HAZARD_BOUNCE_EN
          // Turn around on arrival so each endpoint is lit for exactly one tick.
          if (dir_left) begin
            next_leds = leds << 1;
            if (leds[N_LEDS-2]) next_dir_left = 1'b0;
          end else begin
            next_leds = leds >> 1;
            if (leds[1]) next_dir_left = 1'b1;
          end
`else
          next_leds = (leds == OUTSIDE) ? CENTER : OUTSIDE;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      leds    <= OUTSIDE;
      step    <= 1'b0;
      applied <= M_CALM;
`ifdef HAZARD_BOUNCE_EN
      dir_left <= 1'b0;
`endif
    end else begin
      step <= tick;
      if (enable) count <= tick ? '0 : count + CW'(1);
      if (tick) begin
        leds    <= next_leds;
        applied <= req;
`ifdef HAZARD_BOUNCE_EN
        dir_left <= next_dir_left;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hazard_pattern_gen.sv
// Self-checking bench for hazard_pattern_gen: directed table, multi-cycle corner sequences,
// and randomized traffic against an index-based reference model (honours HAZARD_BOUNCE_EN).
module tb_hazard_pattern_gen;
  localparam int N  = 10;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [1:0]   mode;
  logic [N-1:0] leds;
  logic         step;

  hazard_pattern_gen #(.N_LEDS(N), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .leds(leds), .step(step)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: applied mode, calm phase, lit position, bounce direction
  int m_cnt = 0, m_mode = 0, m_pos = 0, m_dir = -1;
  bit m_center = 1'b0, m_step = 1'b0;

  function automatic int eff_mode(int md);
`ifdef HAZARD_BOUNCE_EN
    return md;
`else
    return (md == 3) ? 0 : md;
`endif
  endfunction

  function automatic logic [N-1:0] model_leds();
    logic [N-1:0] p;
    p = '0;
    if (m_mode == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!m_center) p[i] = (i == 0 || i == N-1);
        else if (N % 2 == 0) p[i] = (i == N/2 || i == N/2-1);
        else p[i] = (i == (N-1)/2);
      end
    end else begin
      p[m_pos] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [N-1:0] onehot(int idx);
    logic [N-1:0] p;
    p = '0;
    p[idx] = 1'b1;
    return p;
  endfunction

  task automatic model_clock(bit r, bit en, int md);
    bit t;
    if (r) begin
      m_cnt = 0; m_mode = 0; m_center = 1'b0; m_step = 1'b0;
    end else if (!en) begin
      m_step = 1'b0;
    end else begin
      t = (m_cnt == TD-1);
      m_cnt = t ? 0 : m_cnt + 1;
      m_step = t;
      if (t) begin
        if (eff_mode(md) != m_mode) begin
          m_mode = eff_mode(md);
          case (m_mode)
            0: m_center = 1'b0;
            1: m_pos = N-1;
            2: m_pos = 0;
            default: begin m_pos = N-1; m_dir = -1; end
          endcase
        end else begin
          case (m_mode)
            0: m_center = !m_center;
            1: m_pos = (m_pos + N - 1) % N;
            2: m_pos = (m_pos + 1) % N;
            default: begin
              m_pos = m_pos + m_dir;
              if (m_pos == 0) m_dir = 1;
              if (m_pos == N-1) m_dir = -1;
            end
          endcase
        end
      end
    end
  endtask

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(bit r, bit en, logic [1:0] md);
    reset = r; enable = en; mode = md;
    model_clock(r, en, int'(md));
    @(posedge clk);
    #1;
    check("model_leds", leds, model_leds());
    check("model_step", {{(N-1){1'b0}}, step}, {{(N-1){1'b0}}, m_step});
  endtask

  typedef struct {
    bit           r;
    bit           en;
    logic [1:0]   md;
    logic [N-1:0] exp_leds;
    bit           exp_step;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit r, bit en, logic [1:0] md, logic [N-1:0] el, bit es);
    vec_t v;
    v.r = r; v.en = en; v.md = md; v.exp_leds = el; v.exp_step = es;
    vt.push_back(v);
  endfunction

  initial begin
    int idx, budget;
    logic [N-1:0] outside_p, center_p;
    outside_p = 10'b1000000001;
    center_p  = 10'b0000110000;
    reset = 1'b1; enable = 1'b0; mode = 2'b00;

    // reset, calm, then switch to wind right
    add(1, 1, 2'b00, outside_p, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, outside_p, 0);
    add(0, 1, 2'b00, center_p, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, center_p, 0);
    add(0, 1, 2'b00, outside_p, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b01, outside_p, 0);
    add(0, 1, 2'b01, 10'b1000000000, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b01, 10'b1000000000, 0);
    add(0, 1, 2'b01, 10'b0100000000, 1);
    foreach (vt[i]) begin
      apply(vt[i].r, vt[i].en, vt[i].md);
      check("vec_leds", leds, vt[i].exp_leds);
      check("vec_step", {{(N-1){1'b0}}, step}, {{(N-1){1'b0}}, vt[i].exp_step});
    end

    // freeze mid wind-right at bit 6 with count 2
    for (int i = 0; i < 10; i++) apply(0, 1, 2'b01);
    check("pre_freeze_leds", leds, 10'b0001000000);
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 2'b10);
      check("freeze_leds", leds, 10'b0001000000);
      check("freeze_step", {{(N-1){1'b0}}, step}, '0);
    end
    apply(0, 1, 2'b01);
    check("thaw1_leds", leds, 10'b0001000000);
    check("thaw1_step", {{(N-1){1'b0}}, step}, '0);
    apply(0, 1, 2'b01);
    check("thaw2_leds", leds, 10'b0000100000);
    check("thaw2_step", {{(N-1){1'b0}}, step}, 10'd1);

    // reset mid wind-left at bit 5
    budget = 0;
    do begin
      apply(0, 1, 2'b10);
      budget++;
    end while (!(m_mode == 2 && m_pos == 5 && m_step) && budget < 200);
    check("reach_wl_bit5", leds, 10'b0000100000);
    apply(1, 1, 2'b10);
    check("rst_leds", leds, outside_p);
    check("rst_step", {{(N-1){1'b0}}, step}, '0);
    for (int i = 0; i < TD; i++) apply(0, 1, 2'b10);
    check("post_rst_reload", leds, 10'b0000000001);
    check("post_rst_step", {{(N-1){1'b0}}, step}, 10'd1);

    // calm at OUTSIDE right after a tick, then switch to 11
    budget = 0;
    do begin
      apply(0, 1, 2'b00);
      budget++;
    end while (!(m_mode == 0 && !m_center && m_step) && budget < 200);
    check("reach_calm_outside", leds, outside_p);
    idx = 0;
    budget = 0;
    while (idx < 19 && budget < 19*TD + 10) begin
      apply(0, 1, 2'b11);
      budget++;
      if (step) begin
`ifdef HAZARD_BOUNCE_EN
        int p;
        p = idx % (2*(N-1));
        check("bounce_seq", leds, onehot(p <= N-1 ? N-1-p : p-(N-1)));
`else
        check("alias_calm_seq", leds, (idx % 2 == 0) ? center_p : outside_p);
`endif
        idx++;
      end
    end
    check("bounce_steps_seen", N'(idx), N'(19));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, en;
      logic [1:0] md;
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      md = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : mode;
      apply(r, en, md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
